// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared datapath types for the pipelined MIPS core
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_AW = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_AW-1:0] regbits_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wbsrc_t;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ldtype_t;

endpackage

`default_nettype wire

// File: rtl/load_ext.sv
// ============================================================================
// load_ext : big-endian byte/halfword extraction and sign/zero extension
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module load_ext
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [2:0]        ldtype,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] raw,
    output logic [WORD_W-1:0] ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 addresses the most significant byte.
    always_comb begin
        w_byte = 8'd0;
        case (offset)
            2'd0: w_byte = raw[WORD_W-1  -: 8];
            2'd1: w_byte = raw[WORD_W-9  -: 8];
            2'd2: w_byte = raw[WORD_W-17 -: 8];
            default: w_byte = raw[WORD_W-25 -: 8];
        endcase
    end

    assign w_half = offset[1] ? raw[15:0] : raw[WORD_W-1 -: 16];

    always_comb begin
        ext = raw;
        case (ldtype)
            LD_B:    ext = {{(WORD_W-8){w_byte[7]}}, w_byte};
            LD_BU:   ext = {{(WORD_W-8){1'b0}}, w_byte};
            LD_H:    ext = {{(WORD_W-16){w_half[15]}}, w_half};
            LD_HU:   ext = {{(WORD_W-16){1'b0}}, w_half};
            default: ext = raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// writeback_stage : MEM/WB latch, writeback mux, sticky halt, retire counter
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module writeback_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wsel,
    input  logic [1:0]        mem_wbsrc,
    input  logic [2:0]        mem_ldtype,
    input  logic [WORD_W-1:0] mem_alu,
    input  logic [WORD_W-1:0] mem_dload,
    input  logic [WORD_W-1:0] mem_pc4,
    input  logic              mem_halt,
    output logic              WEN,
    output logic [REG_AW-1:0] wsel,
    output logic [WORD_W-1:0] wdat,
    output logic              fwd_valid,
    output logic              halt,
    output logic [CNT_W-1:0]  retired
);

    logic              r_valid;
    logic              r_regwrite;
    logic [REG_AW-1:0] r_wsel;
    logic [1:0]        r_wbsrc;
    logic [2:0]        r_ldtype;
    logic [WORD_W-1:0] r_alu;
    logic [WORD_W-1:0] r_dload;
    logic [WORD_W-1:0] r_pc4;
    logic              r_halt_instr;
    logic              r_halt;
    logic [CNT_W-1:0]  r_retired;
    logic [WORD_W-1:0] w_load;

    // Stall outranks flush; only the qualifying bits are cleared on flush.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_valid      <= 1'b0;
            r_regwrite   <= 1'b0;
            r_wsel       <= '0;
            r_wbsrc      <= '0;
            r_ldtype     <= '0;
            r_alu        <= '0;
            r_dload      <= '0;
            r_pc4        <= '0;
            r_halt_instr <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                r_valid      <= 1'b0;
                r_regwrite   <= 1'b0;
                r_halt_instr <= 1'b0;
            end else begin
                r_valid      <= mem_valid;
                r_regwrite   <= mem_regwrite;
                r_wsel       <= mem_wsel;
                r_wbsrc      <= mem_wbsrc;
                r_ldtype     <= mem_ldtype;
                r_alu        <= mem_alu;
                r_dload      <= mem_dload;
                r_pc4        <= mem_pc4;
                r_halt_instr <= mem_halt;
            end
        end
    end

    // The halt instruction itself retires, since r_halt is still clear then.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_halt    <= 1'b0;
            r_retired <= '0;
        end else if (!stall) begin
            if (r_valid && !r_halt) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (r_valid && r_halt_instr) begin
                r_halt <= 1'b1;
            end
        end
    end

    load_ext #(
        .WORD_W (WORD_W)
    ) u_load_ext (
        .ldtype (r_ldtype),
        .offset (r_alu[1:0]),
        .raw    (r_dload),
        .ext    (w_load)
    );

    always_comb begin
        wdat = '0;
        case (r_wbsrc)
            WB_ALU:  wdat = r_alu;
            WB_MEM:  wdat = w_load;
            WB_LINK: wdat = r_pc4;
            default: wdat = '0;
        endcase
    end

    assign WEN       = r_valid & r_regwrite & (r_wsel != '0) & ~r_halt;
    assign wsel      = r_wsel;
    assign fwd_valid = WEN;
    assign halt      = r_halt;
    assign retired   = r_retired;

endmodule

`default_nettype wire
